// File: rtl/radar_stats_avg.sv
`timescale 1ns/1ps
// radar_stats_avg
// Measures ARP revolution period, ACP pulses per revolution and TRIG period
// in microsecond ticks. Periods are block-averaged over 2^AVG_LOG2 samples,
// TRIG extremes are tracked, and an ARP watchdog flags loss of signal.
// All asynchronous inputs are resynchronised into the sys_clk domain.
module radar_stats_avg #(
   parameter int DATA_WIDTH = 32,
   parameter int AVG_LOG2   = 2,
   parameter int TIMEOUT_US = 1000000
) (
   input  logic                  sys_clk,
   input  logic                  resetn,
   input  logic                  us_clk,
   input  logic                  arp,
   input  logic                  acp,
   input  logic                  trig,
   input  logic                  clear,
   output logic                  calibrated,
   output logic                  lost,
   output logic                  update,
   output logic [DATA_WIDTH-1:0] arp_us,
   output logic [DATA_WIDTH-1:0] trig_us,
   output logic [DATA_WIDTH-1:0] acp_cnt,
   output logic [DATA_WIDTH-1:0] trig_min_us,
   output logic [DATA_WIDTH-1:0] trig_max_us
);

   localparam int ACC_W = DATA_WIDTH + AVG_LOG2;
   localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int WD_W  = $clog2(TIMEOUT_US + 1);
   localparam int N_IN  = 4;

   localparam logic [DATA_WIDTH-1:0] ALL_ONES    = '1;
   localparam logic [CNT_W-1:0]      LAST_SAMPLE = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [WD_W-1:0]       WD_LIMIT    = WD_W'(TIMEOUT_US);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_TRACK   = 2'd2,
      ST_LOST    = 2'd3
   } state_t;

   state_t state_reg;
   state_t state_next;

   // ------------------------------------------------------------------
   // Input conditioning: bit 0 us_clk, 1 arp, 2 acp, 3 trig
   // ------------------------------------------------------------------
   logic [N_IN-1:0] pin_async;
   logic [N_IN-1:0] edge_pulse;

   assign pin_async = {trig, acp, arp, us_clk};

   genvar gi;
   generate
      for (gi = 0; gi < N_IN; gi++) begin : g_sync
         logic meta_reg;
         logic sync_reg;
         logic dly_reg;
         logic edge_reg;

         // two-flop synchroniser, delayed copy and registered rising-edge pulse
         always_ff @(posedge sys_clk or negedge resetn) begin
            if (!resetn) begin
               meta_reg <= 1'b0;
               sync_reg <= 1'b0;
               dly_reg  <= 1'b0;
               edge_reg <= 1'b0;
            end else begin
               meta_reg <= pin_async[gi];
               sync_reg <= meta_reg;
               dly_reg  <= sync_reg;
               edge_reg <= sync_reg & ~dly_reg;
            end
         end

         assign edge_pulse[gi] = edge_reg;
      end
   endgenerate

   logic us_tick;
   logic arp_edge;
   logic acp_edge;
   logic trig_edge;

   assign us_tick   = edge_pulse[0];
   assign arp_edge  = edge_pulse[1];
   assign acp_edge  = edge_pulse[2];
   assign trig_edge = edge_pulse[3];

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] arp_run_reg;
   logic [DATA_WIDTH-1:0] trig_run_reg;
   logic [DATA_WIDTH-1:0] acp_run_reg;
   logic [WD_W-1:0]       wd_reg;
   logic                  trig_started_reg;

   logic [ACC_W-1:0]      arp_acc_reg;
   logic [ACC_W-1:0]      trig_acc_reg;
   logic [CNT_W-1:0]      arp_smp_reg;
   logic [CNT_W-1:0]      trig_smp_reg;
   logic                  arp_done_reg;
   logic                  trig_done_reg;

   logic                  update_reg;
   logic [DATA_WIDTH-1:0] arp_us_reg;
   logic [DATA_WIDTH-1:0] trig_us_reg;
   logic [DATA_WIDTH-1:0] acp_cnt_reg;
   logic [DATA_WIDTH-1:0] trig_min_reg;
   logic [DATA_WIDTH-1:0] trig_max_reg;

   // ------------------------------------------------------------------
   // Derived control
   // ------------------------------------------------------------------
   logic                  active;
   logic                  arp_record;
   logic                  trig_record;
   logic                  arp_pub;
   logic                  trig_pub;
   logic                  wd_expired;
   logic [ACC_W-1:0]      arp_sum;
   logic [ACC_W-1:0]      trig_sum;
   logic [DATA_WIDTH-1:0] arp_avg;
   logic [DATA_WIDTH-1:0] trig_avg;

   // Periods are only recorded while acquiring or tracking; the first ARP
   // edge after IDLE/LOST merely moves the FSM, so it never records.
   assign active      = (state_reg == ST_ACQUIRE) || (state_reg == ST_TRACK);
   assign arp_record  = arp_edge && active;
   assign trig_record = trig_edge && active && trig_started_reg;

   assign arp_sum  = arp_acc_reg + ACC_W'(arp_run_reg);
   assign trig_sum = trig_acc_reg + ACC_W'(trig_run_reg);
   assign arp_avg  = DATA_WIDTH'(arp_sum >> AVG_LOG2);
   assign trig_avg = DATA_WIDTH'(trig_sum >> AVG_LOG2);

   assign arp_pub    = arp_record && (arp_smp_reg == LAST_SAMPLE);
   assign trig_pub   = trig_record && (trig_smp_reg == LAST_SAMPLE);
   assign wd_expired = (wd_reg == WD_LIMIT);

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   // state register
   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // next-state and status decode; clear always wins
   always_comb begin
      state_next = state_reg;
      calibrated = 1'b0;
      lost       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (arp_edge) begin
               state_next = ST_ACQUIRE;
            end
         end
         ST_ACQUIRE: begin
            if ((arp_done_reg || arp_pub) && (trig_done_reg || trig_pub)) begin
               state_next = ST_TRACK;
            end else if (wd_expired && !arp_edge) begin
               state_next = ST_LOST;
            end
         end
         ST_TRACK: begin
            calibrated = 1'b1;
            if (wd_expired && !arp_edge) begin
               state_next = ST_LOST;
            end
         end
         ST_LOST: begin
            lost = 1'b1;
            if (arp_edge) begin
               state_next = ST_ACQUIRE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      if (clear) begin
         state_next = ST_IDLE;
      end
   end

   // ------------------------------------------------------------------
   // Counters
   // ------------------------------------------------------------------
   // free-running saturating us counters; an edge restarts them, keeping a coincident tick
   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         arp_run_reg  <= '0;
         trig_run_reg <= '0;
      end else if (clear) begin
         arp_run_reg  <= '0;
         trig_run_reg <= '0;
      end else begin
         if (arp_edge) begin
            arp_run_reg <= DATA_WIDTH'(us_tick);
         end else if (us_tick && (arp_run_reg != ALL_ONES)) begin
            arp_run_reg <= arp_run_reg + DATA_WIDTH'(1);
         end
         if (trig_edge) begin
            trig_run_reg <= DATA_WIDTH'(us_tick);
         end else if (us_tick && (trig_run_reg != ALL_ONES)) begin
            trig_run_reg <= trig_run_reg + DATA_WIDTH'(1);
         end
      end
   end

   // ACP pulses in the current revolution; a coincident ACP belongs to the new one
   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         acp_run_reg <= '0;
      end else if (clear) begin
         acp_run_reg <= '0;
      end else if (arp_edge) begin
         acp_run_reg <= DATA_WIDTH'(acp_edge);
      end else if (acp_edge && (acp_run_reg != ALL_ONES)) begin
         acp_run_reg <= acp_run_reg + DATA_WIDTH'(1);
      end
   end

   // ARP watchdog: ticks since the last ARP edge, parked while idle or lost
   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         wd_reg <= '0;
      end else if (clear || !active) begin
         wd_reg <= '0;
      end else if (arp_edge) begin
         wd_reg <= WD_W'(us_tick);
      end else if (us_tick && !wd_expired) begin
         wd_reg <= wd_reg + WD_W'(1);
      end
   end

   // TRIG measurement arms on the first TRIG edge seen while active
   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         trig_started_reg <= 1'b0;
      end else if (clear || !active) begin
         trig_started_reg <= 1'b0;
      end else if (trig_edge) begin
         trig_started_reg <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Averaging
   // ------------------------------------------------------------------
   // block accumulators; restart from zero on every publish and outside acquisition
   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         arp_acc_reg  <= '0;
         arp_smp_reg  <= '0;
         trig_acc_reg <= '0;
         trig_smp_reg <= '0;
      end else if (clear || !active) begin
         arp_acc_reg  <= '0;
         arp_smp_reg  <= '0;
         trig_acc_reg <= '0;
         trig_smp_reg <= '0;
      end else begin
         if (arp_pub) begin
            arp_acc_reg <= '0;
            arp_smp_reg <= '0;
         end else if (arp_record) begin
            arp_acc_reg <= arp_sum;
            arp_smp_reg <= arp_smp_reg + CNT_W'(1);
         end
         if (trig_pub) begin
            trig_acc_reg <= '0;
            trig_smp_reg <= '0;
         end else if (trig_record) begin
            trig_acc_reg <= trig_sum;
            trig_smp_reg <= trig_smp_reg + CNT_W'(1);
         end
      end
   end

   // per-acquisition flags: has each average been published at least once
   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         arp_done_reg  <= 1'b0;
         trig_done_reg <= 1'b0;
      end else if (clear || !active) begin
         arp_done_reg  <= 1'b0;
         trig_done_reg <= 1'b0;
      end else begin
         if (arp_pub) begin
            arp_done_reg <= 1'b1;
         end
         if (trig_pub) begin
            trig_done_reg <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Published outputs
   // ------------------------------------------------------------------
   // output registers: hold outside acquisition, republish on records
   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         update_reg   <= 1'b0;
         arp_us_reg   <= '0;
         trig_us_reg  <= '0;
         acp_cnt_reg  <= '0;
         trig_min_reg <= ALL_ONES;
         trig_max_reg <= '0;
      end else if (clear) begin
         update_reg   <= 1'b0;
         arp_us_reg   <= '0;
         trig_us_reg  <= '0;
         acp_cnt_reg  <= '0;
         trig_min_reg <= ALL_ONES;
         trig_max_reg <= '0;
      end else begin
         update_reg <= arp_record;
         if (arp_record) begin
            acp_cnt_reg <= acp_run_reg;
         end
         if (arp_pub) begin
            arp_us_reg <= arp_avg;
         end
         if (trig_pub) begin
            trig_us_reg <= trig_avg;
         end
         if (trig_record && (trig_run_reg < trig_min_reg)) begin
            trig_min_reg <= trig_run_reg;
         end
         if (trig_record && (trig_run_reg > trig_max_reg)) begin
            trig_max_reg <= trig_run_reg;
         end
      end
   end

   assign update      = update_reg;
   assign arp_us      = arp_us_reg;
   assign trig_us     = trig_us_reg;
   assign acp_cnt     = acp_cnt_reg;
   assign trig_min_us = trig_min_reg;
   assign trig_max_us = trig_max_reg;

endmodule

// File: tb/tb_radar_stats_avg.sv
`timescale 1ns/1ps
// Bench for radar_stats_avg: pin generators scaled to a 10-clock us tick,
// a table of calibration scenarios, a scoreboard for ACP_CNT on every UPDATE,
// plus hand sequences for LOST, CLEAR in TRACK and asynchronous reset.
module tb_radar_stats_avg;
   localparam int DW     = 32;
   localparam int US_PER = 10;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          us_clk = 1'b0;
   logic          arp = 1'b0;
   logic          acp = 1'b0;
   logic          trig = 1'b0;
   logic          clear = 1'b0;
   logic          calibrated;
   logic          lost;
   logic          update;
   logic [DW-1:0] arp_us;
   logic [DW-1:0] trig_us;
   logic [DW-1:0] acp_cnt;
   logic [DW-1:0] trig_min_us;
   logic [DW-1:0] trig_max_us;

   radar_stats_avg #(
      .DATA_WIDTH(DW),
      .AVG_LOG2  (2),
      .TIMEOUT_US(500)
   ) dut (
      .sys_clk    (clk),
      .resetn     (resetn),
      .us_clk     (us_clk),
      .arp        (arp),
      .acp        (acp),
      .trig       (trig),
      .clear      (clear),
      .calibrated (calibrated),
      .lost       (lost),
      .update     (update),
      .arp_us     (arp_us),
      .trig_us    (trig_us),
      .acp_cnt    (acp_cnt),
      .trig_min_us(trig_min_us),
      .trig_max_us(trig_max_us)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // ---------------- pin generators ----------------
   bit          arp_en   = 1'b0;
   bit          trig_en  = 1'b0;
   bit          trig_alt = 1'b0;
   bit          trig_tog = 1'b0;
   int          arp_per  = 1250;
   int          acp_per  = 250;
   int          acp_off  = 100;
   int          arp_ph   = 0;
   int          rev_idx  = 0;
   longint      cyc      = 0;
   logic [31:0] exp_q[$];

   // us clock, ARP and phase-locked ACP; expected ACP_CNT queued per ARP rise after the first
   initial begin : gen_pins
      forever begin
         @(negedge clk);
         cyc++;
         us_clk = ((cyc % US_PER) < 5);
         if (!arp_en) begin
            arp     = 1'b0;
            acp     = 1'b0;
            arp_ph  = 0;
            rev_idx = 0;
         end else begin
            arp = (arp_ph < 20);
            acp = (((arp_ph + acp_per - acp_off) % acp_per) < 20);
            if (arp_ph == 0) begin
               if (rev_idx > 0) exp_q.push_back(32'(arp_per / acp_per));
               rev_idx++;
            end
            arp_ph = (arp_ph == arp_per - 1) ? 0 : arp_ph + 1;
         end
      end
   end

   // TRIG: 5 us constant, or alternating 4 us / 6 us
   initial begin : gen_trig
      forever begin
         if (trig_en) begin
            trig = 1'b1;
            repeat (5) @(negedge clk);
            trig = 1'b0;
            if (trig_alt) begin
               repeat (trig_tog ? 55 : 35) @(negedge clk);
               trig_tog = !trig_tog;
            end else begin
               repeat (45) @(negedge clk);
            end
         end else begin
            trig_tog = 1'b0;
            trig     = 1'b0;
            @(negedge clk);
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   logic        prev_upd = 1'b0;
   logic [31:0] sb_exp;

   always @(posedge clk) begin
      #1;
      if (update) begin
         check("upd_single_cycle", prev_upd, 0);
         check("upd_has_expect", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            sb_exp = exp_q.pop_front();
            check("acp_cnt_sb", acp_cnt, sb_exp);
            $display("update: acp_cnt=%0d exp=%0d arp_us=%0d trig_us=%0d cal=%0b",
                     acp_cnt, sb_exp, arp_us, trig_us, calibrated);
         end
      end
      prev_upd = update;
   end

   // ---------------- helpers ----------------
   typedef struct {
      int arp_per;
      int acp_per;
      int acp_off;
      bit alt;
      int e_arp;
      int e_acp;
      int e_trig;
      int e_min;
      int e_max;
   } row_t;

   row_t rows[4];

   task automatic check_reset_vals(input string tag);
      check({tag, "_calibrated"}, calibrated, 0);
      check({tag, "_lost"}, lost, 0);
      check({tag, "_update"}, update, 0);
      check({tag, "_arp_us"}, arp_us, 0);
      check({tag, "_trig_us"}, trig_us, 0);
      check({tag, "_acp_cnt"}, acp_cnt, 0);
      check({tag, "_trig_min"}, trig_min_us, 64'h0000_0000_FFFF_FFFF);
      check({tag, "_trig_max"}, trig_max_us, 0);
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic start_run(input row_t r);
      @(negedge clk);
      #1;
      arp_per  = r.arp_per;
      acp_per  = r.acp_per;
      acp_off  = r.acp_off;
      trig_alt = r.alt;
      arp_en   = 1'b1;
      trig_en  = 1'b1;
   endtask

   // wait for CALIBRATED; it must rise together with the 4th UPDATE
   task automatic wait_cal(input string tag, input int bound);
      int n    = 0;
      int upds = 0;
      bit got  = 1'b0;
      while (n < bound && !got) begin
         @(posedge clk);
         #1;
         n++;
         if (update) upds++;
         if (calibrated) got = 1'b1;
      end
      check({tag, "_cal_reached"}, got, 1);
      if (got) begin
         check({tag, "_upd_before_cal"}, upds, 4);
         check({tag, "_upd_at_cal"}, update, 1);
      end
   endtask

   task automatic wait_update(input string tag, input int bound);
      int n   = 0;
      bit got = 1'b0;
      while (n < bound && !got) begin
         @(posedge clk);
         #1;
         n++;
         got = update;
      end
      check({tag, "_update_seen"}, got, 1);
   endtask

   initial begin : guard
      #950000;
      $display("FAIL global_timeout: simulation did not finish, limit 950000 ns");
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   initial begin : main
      int    n;
      string tag;

      rows[0] = '{1250, 250, 100, 1'b0, 125, 5,  5, 5, 5};
      rows[1] = '{1250, 250,   0, 1'b0, 125, 5,  5, 5, 5};
      rows[2] = '{1000, 125,  60, 1'b1, 100, 8,  5, 4, 6};
      rows[3] = '{1250, 250,   0, 1'b1, 125, 5,  5, 4, 6};

      resetn = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("por");
      $display("reset: cal=%0b lost=%0b min=%0h max=%0d", calibrated, lost, trig_min_us, trig_max_us);
      resetn = 1'b1;

      for (int i = 0; i < 4; i++) begin
         tag     = $sformatf("row%0d", i);
         arp_en  = 1'b0;
         trig_en = 1'b0;
         repeat (100) @(negedge clk);
         check({tag, "_queue_drained"}, exp_q.size(), 0);
         do_clear();
         check_reset_vals({tag, "_clr"});
         start_run(rows[i]);
         wait_cal(tag, 8 * rows[i].arp_per);
         check({tag, "_arp_us"}, arp_us, rows[i].e_arp);
         check({tag, "_acp_cnt"}, acp_cnt, rows[i].e_acp);
         check({tag, "_trig_us"}, trig_us, rows[i].e_trig);
         check({tag, "_trig_min"}, trig_min_us, rows[i].e_min);
         check({tag, "_trig_max"}, trig_max_us, rows[i].e_max);
         $display("%s: arp_us=%0d acp_cnt=%0d trig_us=%0d min=%0d max=%0d cal=%0b",
                  tag, arp_us, acp_cnt, trig_us, trig_min_us, trig_max_us, calibrated);
      end

      // ARP stops in TRACK: LOST about 500 ticks after the last ARP edge
      wait_update("lost", 2 * 1250);
      arp_en = 1'b0;
      n = 0;
      while (n < 6000 && !lost) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 4900) begin
            check("lost_early_lost", lost, 0);
            check("lost_early_cal", calibrated, 1);
         end
      end
      check("lost_asserted", lost, 1);
      check("lost_timing_window", (n >= 4970) && (n <= 5015), 1);
      check("lost_cal_low", calibrated, 0);
      check("lost_hold_arp_us", arp_us, 125);
      check("lost_hold_acp_cnt", acp_cnt, 5);
      check("lost_hold_trig_us", trig_us, 5);
      check("lost_hold_trig_min", trig_min_us, 4);
      check("lost_hold_trig_max", trig_max_us, 6);
      $display("lost: after %0d clk from last update, cal=%0b arp_us=%0d", n, calibrated, arp_us);

      // ARP returns: LOST clears on the first edge, recalibrates after 5 edges
      @(negedge clk);
      #1;
      arp_en = 1'b1;
      n = 0;
      while (n < 100 && lost) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("relock_lost_cleared", lost, 0);
      check("relock_cal_low", calibrated, 0);
      wait_cal("relock", 8 * 1250);
      check("relock_arp_us", arp_us, 125);
      $display("relock: cal=%0b arp_us=%0d acp_cnt=%0d", calibrated, arp_us, acp_cnt);

      // CLEAR in TRACK, mid revolution
      wait_update("clrtrk", 2 * 1250);
      repeat (100) @(negedge clk);
      clear  = 1'b1;
      arp_en = 1'b0;
      @(negedge clk);
      clear = 1'b0;
      check_reset_vals("clrtrk");
      repeat (5500) @(negedge clk);
      check("clrtrk_idle_no_lost", lost, 0);
      check("clrtrk_idle_cal", calibrated, 0);
      $display("clear in track: cal=%0b lost=%0b arp_us=%0d", calibrated, lost, arp_us);

      // asynchronous reset between clock edges
      start_run(rows[0]);
      wait_cal("rearm", 8 * 1250);
      repeat (300) @(negedge clk);
      check("pre_rst_arp_us", arp_us, 125);
      #3;
      resetn = 1'b0;
      #1;
      check_reset_vals("async_rst");
      $display("async reset: cal=%0b arp_us=%0d acp_cnt=%0d", calibrated, arp_us, acp_cnt);
      arp_en  = 1'b0;
      trig_en = 1'b0;
      repeat (10) @(negedge clk);
      exp_q.delete();
      resetn = 1'b1;
      repeat (5) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/radar_stats_avg.md
# radar_stats_avg

Parametrised successor to the radar statistics block: measures ARP revolution period, ACP pulses per revolution and TRIG period in microsecond ticks, averages periods over 2^AVG_LOG2 samples, and tracks TRIG min/max. It adds loss-of-signal watchdog, a synchronous statistics clear and a per-update strobe. Sits between the radar input conditioning and the AXI register bank that feeds the simulator software.

## Interface
- DATA_WIDTH, 32: width of all period/count outputs and internal counters.
- AVG_LOG2, 2: ARP_US and TRIG_US are block averages of 2^AVG_LOG2 periods (0 = no averaging).
- TIMEOUT_US, 1000000: US ticks without an ARP edge before signal is declared lost.
- SYS_CLK  in  1  system clock; all logic on rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- US_CLK  in  1  1 MHz reference, asynchronous; each rising edge is one µs tick.
- ARP, ACP, TRIG  in  1 each  asynchronous radar pulses; rising edge significant.
- CLEAR  in  1  synchronous, single-cycle; discards all statistics.
- CALIBRATED  out  1  all outputs hold valid averaged data.
- LOST  out  1  ARP watchdog expired.
- UPDATE  out  1  one-cycle strobe when ARP_US/ACP_CNT are republished.
- ARP_US, TRIG_US  out  DATA_WIDTH  averaged periods in µs.
- ACP_CNT  out  DATA_WIDTH  ACP edges in last complete revolution.
- TRIG_MIN_US, TRIG_MAX_US  out  DATA_WIDTH  extreme single TRIG periods since calibration start.

## Operation
- Each of US_CLK, ARP, ACP, TRIG: 2-FF synchroniser, then edge register; rising edge = sync & ~delayed.
- Free-running per-signal µs counters (ARP, TRIG) increment on tick, saturate at 2^DATA_WIDTH-1. On that signal's edge: period = counter value; counter loads 1 if a tick coincides, else 0.
- First edge after reset/CLEAR/LOST only starts the counter; no period recorded.
- Accumulator width DATA_WIDTH+AVG_LOG2; after 2^AVG_LOG2 periods output <= sum >> AVG_LOG2, accumulator restarts with zero.
- ACP counter increments per ACP edge; on ARP edge ACP_CNT candidate = count, counter reloads 1 if ACP edge coincides with ARP edge, else 0.
- TRIG_MIN/MAX updated on every recorded TRIG period (min init all-ones, max init 0).
- State machine:
  - IDLE: waiting first ARP edge -> ACQUIRE.
  - ACQUIRE: gathering; -> TRACK when first ARP average and first TRIG average both published.
  - TRACK: CALIBRATED=1; outputs keep updating.
  - LOST: entered from ACQUIRE/TRACK when ARP watchdog reaches TIMEOUT_US; CALIBRATED=0, LOST=1, outputs hold last values; next ARP edge -> ACQUIRE (LOST clears, accumulators zeroed).
- Watchdog counts ticks, cleared on every ARP edge; inactive in IDLE.
- CLEAR (any state): -> IDLE, all counters/accumulators/outputs to reset values, next cycle. CLEAR overrides simultaneous edges.

## Timing
- Reset values: CALIBRATED=0, LOST=0, UPDATE=0, ARP_US=0, TRIG_US=0, ACP_CNT=0, TRIG_MIN_US=all-ones, TRIG_MAX_US=0; state IDLE.
- Input pin rise to internal edge pulse: 3 SYS_CLK (2 sync + 1 edge).
- Edge pulse to output register update: 1 SYS_CLK; UPDATE asserted same cycle as ARP_US/ACP_CNT change.
- ACP_CNT and UPDATE issue every ARP edge after the first; ARP_US changes only every 2^AVG_LOG2 revolutions.
- CALIBRATED rises in the same cycle as the publishing that completes both averages.
- LOST asserts the cycle after watchdog count equals TIMEOUT_US.
- Inputs must be high and low ≥2 SYS_CLK each; shorter pulses may be missed.

## Test plan
- SYS_CLK 10 ns, US_CLK period 100 clk, TRIG 500, ACP 2500, ARP 12500 clk, AVG_LOG2=2 -> after 5 ARP edges CALIBRATED=1, ARP_US=125, ACP_CNT=5, TRIG_US=5, TRIG_MIN/MAX=5.
- Alternate TRIG periods 4 µs/6 µs -> TRIG_US=5, TRIG_MIN_US=4, TRIG_MAX_US=6.
- Stop ARP with TIMEOUT_US=500 -> LOST=1, CALIBRATED=0 exactly 500 ticks after last edge; restart ARP -> LOST=0, CALIBRATED again after 5 edges.
- CLEAR pulse while TRACK -> next cycle all outputs at reset values, state IDLE, UPDATE=0.
- Async RESETN low mid-revolution -> outputs immediately reset values regardless of SYS_CLK.
- ACP edge coincident with ARP edge -> counted in new revolution; ACP_CNT stays 5, UPDATE one cycle per revolution.
